// File: rtl/dds_pkg.sv
// Shared constants and elaboration-time helpers for the DDS waveform generator:
// one-hot wave codes, mid-scale value and the quarter-wave sine table entries.
package dds_pkg;

   localparam logic [3:0] WAVE_SINE   = 4'b0001;
   localparam logic [3:0] WAVE_SQUARE = 4'b0010;
   localparam logic [3:0] WAVE_TRI    = 4'b0100;
   localparam logic [3:0] WAVE_SAW    = 4'b1000;

   typedef enum logic [2:0] {
      SEL_MID,
      SEL_SINE,
      SEL_SQUARE,
      SEL_TRI,
      SEL_SAW
   } wave_sel_e;

   function automatic int mid_scale(input int data_w);
      return 1 << (data_w - 1);
   endfunction

   // Anything that is not exactly one-hot parks the output at mid-scale.
   function automatic wave_sel_e decode_wave(input logic [3:0] w);
      case (w)
         WAVE_SINE:   return SEL_SINE;
         WAVE_SQUARE: return SEL_SQUARE;
         WAVE_TRI:    return SEL_TRI;
         WAVE_SAW:    return SEL_SAW;
         default:     return SEL_MID;
      endcase
   endfunction

   // Entry k of the quarter-wave table, sampled at half-step centres so the
   // mirrored quadrants need no extra offset. A Taylor series keeps this
   // independent of tool support for real math system functions.
   function automatic int sine_entry(input int k, input int addr_w, input int data_w);
      real x, term, s;
      x    = 2.0 * 3.14159265358979 * (real'(k) + 0.5) / real'(1 << addr_w);
      term = x;
      s    = x;
      for (int i = 1; i < 12; i++) begin
         term = -term * x * x / real'((2 * i) * (2 * i + 1));
         s    = s + term;
      end
      return $rtoi(real'(mid_scale(data_w) - 1) * s + 0.5);
   endfunction

endpackage

// File: rtl/dds_wave_gen_if.sv
// Configuration handshake and DAC-side outputs of the DDS waveform generator.
interface dds_wave_gen_if #(
   parameter int PHASE_W = 32,
   parameter int DATA_W  = 8
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [PHASE_W-1:0] cfg_freq;
   logic [PHASE_W-1:0] cfg_phase;
   logic [3:0]         cfg_wave;
   logic [DATA_W-1:0]  dac_data;
   logic               dac_valid;
   logic               wrap;

   modport master (
      output cfg_valid, cfg_freq, cfg_phase, cfg_wave,
      input  cfg_ready, dac_data, dac_valid, wrap
   );

   modport slave (
      input  cfg_valid, cfg_freq, cfg_phase, cfg_wave,
      output cfg_ready, dac_data, dac_valid, wrap
   );
endinterface

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine ROM with registered read; folds the quarter index and
// applies the half-wave sign so the output is a full offset-binary sample.
module dds_sine_lut
   import dds_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] sample
);
   localparam int QN = 1 << (ADDR_W - 2);
   localparam logic [DATA_W-1:0] MID = DATA_W'(mid_scale(DATA_W));

   logic [QN-1:0][DATA_W-1:0] rom;
   logic [ADDR_W-3:0]         idx;
   logic [DATA_W-1:0]         ent;

   for (genvar k = 0; k < QN; k++) begin : g_rom
      localparam logic [DATA_W-1:0] ENT = DATA_W'(sine_entry(k, ADDR_W, DATA_W));
      assign rom[k] = ENT;
   end

   // Second and fourth quadrants run the table backwards.
   assign idx = addr[ADDR_W-2] ? ~addr[ADDR_W-3:0] : addr[ADDR_W-3:0];
   assign ent = rom[idx];

   always_ff @(posedge clk) begin
      if (rst) sample <= MID;
      else     sample <= addr[ADDR_W-1] ? (MID - ent) : (MID + ent);
   end
endmodule

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS with glitch-free config updates (applied on phase wrap)
// and a two-stage sample pipeline feeding an offset-binary DAC.
module dds_wave_gen
   import dds_pkg::*;
#(
   parameter int PHASE_W = 32,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 8
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   dds_wave_gen_if.slave  dds
);
   localparam int STAGES = 2;
   localparam int TOP_W  = (ADDR_W > DATA_W + 1) ? ADDR_W : DATA_W + 1;
   localparam logic [DATA_W-1:0] MID = DATA_W'(mid_scale(DATA_W));

   logic [PHASE_W-1:0] acc, freq_act, phase_act, freq_sh, phase_sh;
   logic [3:0]         wave_act, wave_sh;
   logic               pending, wrap_q;
   logic [PHASE_W:0]   acc_sum;
   logic               carry, accept, apply;

   assign acc_sum = {1'b0, acc} + {1'b0, freq_act};
   assign carry   = acc_sum[PHASE_W];
   assign accept  = dds.cfg_valid && !pending;
   // A stopped accumulator never wraps, so a pending config must not wait for one.
   assign apply   = pending && (carry || (freq_act == '0));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         acc       <= '0;
         freq_act  <= '0;
         phase_act <= '0;
         wave_act  <= '0;
         freq_sh   <= '0;
         phase_sh  <= '0;
         wave_sh   <= '0;
         pending   <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         acc    <= acc_sum[PHASE_W-1:0];
         wrap_q <= carry;
         if (apply) begin
            freq_act  <= freq_sh;
            phase_act <= phase_sh;
            wave_act  <= wave_sh;
         end
         if (accept) begin
            freq_sh  <= dds.cfg_freq;
            phase_sh <= dds.cfg_phase;
            wave_sh  <= dds.cfg_wave;
         end
         pending <= accept | (pending & ~apply);
      end
   end

   assign dds.cfg_ready = !pending;
   assign dds.wrap      = wrap_q;

   // Stage 1: offset phase (only the bits any waveform looks at) and decoded wave.
   logic [PHASE_W-1:0] p_sum;
   logic [TOP_W-1:0]   p1;
   wave_sel_e          sel1, sel2;
   logic [DATA_W-1:0]  shape_d, shape2, sine2;
   logic [DATA_W:0]    tri_u;
   logic [STAGES-1:0]  vld_pipe;

   assign p_sum = acc + phase_act;

   if (PHASE_W > TOP_W) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^p_sum[PHASE_W-TOP_W-1:0];
   end

   assign tri_u = p1[TOP_W-1 -: DATA_W+1];

   always_comb begin
      shape_d = MID;
      case (sel1)
         SEL_SQUARE: shape_d = p1[TOP_W-1] ? '0 : '1;
         SEL_TRI:    shape_d = tri_u[DATA_W] ? ~tri_u[DATA_W-1:0] : tri_u[DATA_W-1:0];
         SEL_SAW:    shape_d = p1[TOP_W-1 -: DATA_W];
         default:    shape_d = MID;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         p1       <= '0;
         sel1     <= SEL_MID;
         sel2     <= SEL_MID;
         shape2   <= MID;
         vld_pipe <= '0;
      end else begin
         p1       <= p_sum[PHASE_W-1 -: TOP_W];
         sel1     <= decode_wave(wave_act);
         sel2     <= sel1;
         shape2   <= shape_d;
         vld_pipe <= {vld_pipe[STAGES-2:0], 1'b1};
      end
   end

   // The ROM read is the stage-2 register for the sine path.
   dds_sine_lut #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_sine (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .addr   (p1[TOP_W-1 -: ADDR_W]),
      .sample (sine2)
   );

   assign dds.dac_data  = (sel2 == SEL_SINE) ? sine2 : shape2;
   assign dds.dac_valid = vld_pipe[STAGES-1];
endmodule
